cnu_min_ctrl: RTL and testbench

- Serial check-node controller for the min-sum LDPC decoder.
- Accepts one sign-magnitude variable-to-check message per cycle over a valid/ready stream and tracks the sign product across the row.
- Sequences a running two-minimum update: min1, min2 and the index of min1.
- After deg messages, presents the check-node summary on an output valid/ready port for the check-to-variable message generator.

---
 rtl/cnu_pkg.sv | 26 ++
 rtl/min2_update.sv | 30 +++
 rtl/cnu_min_ctrl.sv | 119 +++++++++++
 tb/tb_cnu_min_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// Shared definitions for the serial min-sum check-node controller:
// FSM encoding, magnitude init value and row-degree clamp.
package cnu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  // All-ones value of a w-bit magnitude (w <= 32).
  function automatic logic [31:0] mag_init(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Row degree limited to [2, 2**idx_w] so the beat counter never wraps.
  function automatic logic [31:0] deg_clamp(input logic [31:0] deg, input int idx_w);
    logic [31:0] dmax;
    dmax = 32'd1 << idx_w;
    if (deg < 32'd2) return 32'd2;
    if (deg > dmax)  return dmax;
    return deg;
  endfunction

endpackage

// File: rtl/min2_update.sv
// Combinational two-minimum update step; strict compares keep the earlier
// index on ties. Shared with the parallel compare tree.
module min2_update #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic [DATA_W-1:0] min1_i,
  input  logic [DATA_W-1:0] min2_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] mag_i,
  input  logic [IDX_W-1:0]  cnt_i,
  output logic [DATA_W-1:0] min1_o,
  output logic [DATA_W-1:0] min2_o,
  output logic [IDX_W-1:0]  idx_o
);

  always_comb begin
    min1_o = min1_i;
    min2_o = min2_i;
    idx_o  = idx_i;
    if (mag_i < min1_i) begin
      min2_o = min1_i;
      min1_o = mag_i;
      idx_o  = cnt_i;
    end else if (mag_i < min2_i) begin
      min2_o = mag_i;
    end
  end

endmodule

// File: rtl/cnu_min_ctrl.sv
// Serial check-node controller: accumulates sign product and min1/min2/idx
// over a row of deg messages, then holds the summary until downstream takes it.
module cnu_min_ctrl
  import cnu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W:0]    deg_cfg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min1,
  output logic [DATA_W-1:0] out_min2,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_sign,
  output logic              busy
);

  localparam int DEG_W = IDX_W + 1;
  localparam logic [DATA_W-1:0] MAG_INIT = DATA_W'(mag_init(DATA_W));

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   min1_q, min1_d, min2_q, min2_d;
  logic [IDX_W-1:0]    idx_q, idx_d, cnt_q, cnt_d;
  logic [DEG_W-1:0]    deg_q, deg_d, deg_eff;
  logic                sign_q, sign_d, last_beat;
  logic [DATA_W-1:0]   upd_min1, upd_min2;
  logic [IDX_W-1:0]    upd_idx;

  min2_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_upd (
    .min1_i (min1_q),
    .min2_i (min2_q),
    .idx_i  (idx_q),
    .mag_i  (in_mag),
    .cnt_i  (cnt_q),
    .min1_o (upd_min1),
    .min2_o (upd_min2),
    .idx_o  (upd_idx)
  );

  assign deg_eff   = DEG_W'(deg_clamp(32'(deg_cfg), IDX_W));
  assign last_beat = ({1'b0, cnt_q} == (deg_q - DEG_W'(1)));

  always_comb begin
    state_d = state_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    deg_d   = deg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          deg_d   = deg_eff;
          min1_d  = in_mag;
          min2_d  = MAG_INIT;
          idx_d   = '0;
          sign_d  = in_sign;
          cnt_d   = IDX_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          min1_d = upd_min1;
          min2_d = upd_min2;
          idx_d  = upd_idx;
          sign_d = sign_q ^ in_sign;
          cnt_d  = cnt_q + IDX_W'(1);
          if (last_beat) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min1_q  <= MAG_INIT;
      min2_q  <= MAG_INIT;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      deg_q   <= DEG_W'(2);
    end else begin
      state_q <= state_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      deg_q   <= deg_d;
    end
  end

  // in_ready is held low while reset is asserted, whatever the state.
  assign in_ready  = rst_n && (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == ACCUM);
  assign out_min1  = min1_q;
  assign out_min2  = min2_q;
  assign out_idx   = idx_q;
  assign out_sign  = sign_q;

endmodule

// File: tb/tb_cnu_min_ctrl.sv
// Bench for cnu_min_ctrl: a row-level reference model (queue of magnitudes,
// min/argmin over the row) checked every cycle, plus literal row expectations.
module tb_cnu_min_ctrl;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 5;
  localparam int ALL1   = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IDX_W:0]    deg_cfg = '0;
  logic              in_valid = 1'b0;
  logic              in_sign = 1'b0;
  logic [DATA_W-1:0] in_mag = '0;
  logic              out_ready = 1'b1;
  logic              in_ready, out_valid, out_sign, busy;
  logic [DATA_W-1:0] out_min1, out_min2;
  logic [IDX_W-1:0]  out_idx;

  always #5 clk = ~clk;

  cnu_min_ctrl #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .deg_cfg(deg_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min1(out_min1), .out_min2(out_min2), .out_idx(out_idx),
    .out_sign(out_sign), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int row[$];
  int m_deg = 2;
  bit m_sign = 1'b0, m_out = 1'b0, m_fresh = 1'b1, m_en = 1'b0;
  int e_min1 = ALL1, e_min2 = ALL1, e_idx = 0;
  bit e_sign = 1'b0;

  // Literal expectations for directed rows (written by stimulus only)
  bit lit_en = 1'b0;
  int lit_min1 = 0, lit_min2 = 0, lit_idx = 0;
  bit lit_sign = 1'b0;

  always @(posedge clk) begin
    m_en = 1'b1;
    if (!rst_n) begin
      row.delete();
      m_out = 1'b0; m_fresh = 1'b1; m_sign = 1'b0;
      e_min1 = ALL1; e_min2 = ALL1; e_idx = 0; e_sign = 1'b0;
    end else if (m_out) begin
      if (out_ready) m_out = 1'b0;
    end else if (in_valid) begin
      if (row.size() == 0) begin
        m_deg = int'(deg_cfg);
        if (m_deg < 2) m_deg = 2;
        if (m_deg > (1 << IDX_W)) m_deg = 1 << IDX_W;
        m_sign = 1'b0;
        m_fresh = 1'b0;
      end
      row.push_back(int'(in_mag));
      m_sign = m_sign ^ in_sign;
      if (row.size() == m_deg) begin
        e_min1 = row[0]; e_idx = 0;
        foreach (row[j]) if (row[j] < e_min1) begin e_min1 = row[j]; e_idx = j; end
        e_min2 = ALL1 + 1;
        foreach (row[j]) if (j != e_idx && row[j] < e_min2) e_min2 = row[j];
        e_sign = m_sign;
        m_out = 1'b1;
        row.delete();
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_en) begin
      chk("in_ready", int'(in_ready), int'(rst_n && !m_out));
      chk("out_valid", int'(out_valid), int'(m_out));
      chk("busy", int'(busy), int'(row.size() > 0));
      if (m_out || m_fresh) begin
        chk("min1", int'(out_min1), e_min1);
        chk("min2", int'(out_min2), e_min2);
        chk("idx", int'(out_idx), e_idx);
        chk("sign", int'(out_sign), int'(e_sign));
      end
      if (m_out && lit_en) begin
        chk("lit_min1", e_min1, lit_min1);
        chk("lit_min2", e_min2, lit_min2);
        chk("lit_idx", e_idx, lit_idx);
        chk("lit_sign", int'(e_sign), int'(lit_sign));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int m, input bit s);
    in_valid = 1'b1; in_mag = DATA_W'(m); in_sign = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_lit(input int a, input int b, input int i, input bit s);
    lit_min1 = a; lit_min2 = b; lit_idx = i; lit_sign = s; lit_en = 1'b1;
  endtask

  task automatic finish_row();
    for (int k = 0; k < 200 && m_out; k++) step();
    lit_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();

    out_ready = 1'b1; deg_cfg = 4; set_lit(3, 5, 1, 1'b1);
    beat(7, 0); beat(3, 1); beat(9, 1); beat(5, 1); finish_row();
    step();

    deg_cfg = 3; set_lit(4, 4, 0, 1'b0);
    beat(4, 0); beat(4, 0); beat(6, 0); finish_row();
    set_lit(2, 2, 0, 1'b0);
    beat(2, 0); beat(8, 0); beat(2, 0); finish_row();

    out_ready = 1'b0; deg_cfg = 2; set_lit(5, 6, 0, 1'b1);
    beat(5, 1); beat(6, 0);
    in_valid = 1'b1; in_mag = 8'd1; deg_cfg = 7;
    repeat (5) step();
    in_valid = 1'b0; out_ready = 1'b1; finish_row();

    deg_cfg = 0; set_lit(3, 9, 1, 1'b0);
    beat(9, 0); beat(3, 0); finish_row();

    deg_cfg = 40; set_lit(1, 100, 31, 1'b0);
    for (int k = 0; k < 32; k++) begin
      beat((k == 31) ? 1 : 100, 0);
      deg_cfg = 2;
    end
    finish_row();

    deg_cfg = 6;
    beat(10, 1); step(); beat(20, 0); step(); beat(30, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    deg_cfg = 2; set_lit(1, 10, 1, 1'b0);
    beat(10, 0); beat(1, 0); finish_row();

    deg_cfg = 3; set_lit(255, 255, 0, 1'b1);
    beat(255, 1); beat(255, 1); beat(255, 1); finish_row();

    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mag    = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom_range(0, 7))
                                              : DATA_W'($urandom_range(0, ALL1));
      in_sign   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      deg_cfg   = ($urandom_range(0, 9) == 0) ? (IDX_W+1)'($urandom_range(0, 63))
                                              : (IDX_W+1)'($urandom_range(0, 8));
      rst_n     = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
